ddr2_traffic_gen: RTL and testbench
===================================

Name: ddr2_traffic_gen

Overview:
- Self-checking traffic generator and checker for the MIG DDR2 user (app) interface.
- Successor to the fixed 16-bit pipe bridge used by the RAMTester. Generalised in app data width, burst size, base address and burst count.
- Adds on-chip LFSR pattern generation, write/read-verify/combined modes, error counting and a read timeout.
- Sits beside ddr2_top on clk0 and drives the app_af / app_wdf ports directly; the host only sees its control and status ports.

Parameters:
- APPDATA_WIDTH, 32: app data bus width; must be a multiple of 32.
- ADDR_WIDTH, 31: width of app_af_addr.
- BURST_WORDS, 2: app data words per burst (BL4 on a x16 DDR2 device gives 2).
- ADDR_STEP, 4: app_af_addr increment per burst.
- CNT_WIDTH, 16: width of num_bursts and err_count.
- TIMEOUT, 4096: clk cycles with no rd_data_valid while reads are outstanding before a timeout is declared.

Ports:
- clk  in  1  clk0 domain clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- mode  in  2  0 = write, 1 = read-verify, 2 = write then read-verify, 3 = no-op.
- base_addr  in  ADDR_WIDTH  first burst address.
- num_bursts  in  CNT_WIDTH  number of bursts; 0 means no-op.
- seed  in  32  LFSR seed; an all-zero seed is replaced by 32'h0000_0001.
- phy_init_done  in  1  from ddr2_top.
- app_af_afull  in  1  address FIFO almost full.
- app_wdf_afull  in  1  write-data FIFO almost full.
- rd_data_valid  in  1  read data valid.
- rd_data_fifo_out  in  APPDATA_WIDTH  read data.
- app_af_wren  out  1  address/command write enable.
- app_af_addr  out  ADDR_WIDTH  address.
- app_af_cmd  out  3  3'b000 = write, 3'b001 = read.
- app_wdf_wren  out  1  write-data enable.
- app_wdf_data  out  APPDATA_WIDTH  write data.
- app_wdf_mask_data  out  APPDATA_WIDTH/8  always 0.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at completion.
- error  out  1  sticky; set on any mismatch or on timeout.
- timeout  out  1  sticky; read timeout occurred.
- err_count  out  CNT_WIDTH  number of mismatching words, saturating at all-ones.
- first_err_addr  out  ADDR_WIDTH  burst address of the first mismatch.

Behaviour:
- Reset (reset_n low at a clk edge): all outputs 0, FSM to IDLE, counters and LFSRs cleared. A reset mid-operation aborts immediately with no further wren strobes, even if a burst is half written.
- Pattern: 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1. It advances once per data word. Data word = the LFSR state replicated APPDATA_WIDTH/32 times. The generator and checker LFSRs are both loaded with the seed at start.
- FSM states and transitions:
  - IDLE: on start, latch mode, base_addr, num_bursts and seed, and clear error, timeout, err_count and first_err_addr. If mode == 3 or num_bursts == 0, go to DONE. Otherwise go to WAIT_INIT.
  - WAIT_INIT: hold until phy_init_done = 1. Then go to WR_DATA (modes 0 and 2) or RD_CMD (mode 1).
  - WR_DATA: assert app_wdf_wren for each cycle where app_wdf_afull = 0, up to BURST_WORDS words. Stall with wren low while afull is high. Go to WR_CMD after the last word.
  - WR_CMD: assert app_af_wren with cmd 000 and the current address for one cycle once app_af_afull = 0. Address += ADDR_STEP, modulo 2^ADDR_WIDTH, wrapping silently. If more bursts remain, go to WR_DATA. Otherwise go to RD_CMD in mode 2 (address and generator LFSR reloaded) or to DONE in mode 0.
  - RD_CMD: issue one read command per cycle while app_af_afull = 0, num_bursts in total. Go to RD_DRAIN after the last one.
  - RD_DRAIN: wait until all num_bursts × BURST_WORDS words have been received, then go to DONE.
  - DONE: pulse done for one cycle, then return to IDLE.
- Checker: active in RD_CMD and RD_DRAIN. Each rd_data_valid word is compared with the checker LFSR, which then advances.
  - On mismatch, err_count increments (saturating) and error is set.
  - first_err_addr captures the address of the burst containing the word, but only on the first mismatch.
  - rd_data_valid outside the read phase is ignored.
- Timeout: in RD_CMD and RD_DRAIN, a counter resets on every valid word and increments otherwise. When it reaches TIMEOUT, set timeout and error and go to DONE.
- Handshakes: app_af_wren and app_wdf_wren are never asserted in the cycle their afull input is high. Write data for a burst always precedes its command. The afull inputs are sampled in the same cycle as the strobe.

Test Plan:
- mode 2, base_addr 0, num_bursts 8, seed 1, no backpressure, ideal memory model -> 16 wdf writes, 8 write commands at addresses 0..28 step 4, 8 reads; done pulse with error = 0 and err_count = 0.
- mode 2 with app_wdf_afull and app_af_afull toggled pseudo-randomly -> no strobe ever coincides with afull; same data and addresses as the first case; error = 0.
- mode 1 after a write with seed 5, with the model flipping bit 0 of read word 3 -> err_count = 1, error = 1, first_err_addr = base + 4.
- mode 1 with the model returning no read data -> timeout = 1 and error = 1 after TIMEOUT cycles; done pulses.
- base_addr = 2^31 − 4, num_bursts 2 -> second command at address 0.
- reset_n low mid-WR_DATA -> outputs 0 next cycle; a subsequent start runs cleanly. start with num_bursts 0 -> done pulse within 2 cycles and no wren strobes.

Source files
------------

// File: rtl/ddr2_traffic_gen.sv
// Self-checking traffic generator/checker for the MIG DDR2 app interface.
// Writes LFSR-patterned bursts, reads them back and counts mismatching words.
module ddr2_traffic_gen #(
    parameter int APPDATA_WIDTH = 32,
    parameter int ADDR_WIDTH    = 31,
    parameter int BURST_WORDS   = 2,
    parameter int ADDR_STEP     = 4,
    parameter int CNT_WIDTH     = 16,
    parameter int TIMEOUT       = 4096
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [1:0]                 mode,
    input  logic [ADDR_WIDTH-1:0]      base_addr,
    input  logic [CNT_WIDTH-1:0]       num_bursts,
    input  logic [31:0]                seed,
    input  logic                       phy_init_done,
    input  logic                       app_af_afull,
    input  logic                       app_wdf_afull,
    input  logic                       rd_data_valid,
    input  logic [APPDATA_WIDTH-1:0]   rd_data_fifo_out,
    output logic                       app_af_wren,
    output logic [ADDR_WIDTH-1:0]      app_af_addr,
    output logic [2:0]                 app_af_cmd,
    output logic                       app_wdf_wren,
    output logic [APPDATA_WIDTH-1:0]   app_wdf_data,
    output logic [APPDATA_WIDTH/8-1:0] app_wdf_mask_data,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic                       timeout,
    output logic [CNT_WIDTH-1:0]       err_count,
    output logic [ADDR_WIDTH-1:0]      first_err_addr
);
    localparam int WW = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int REP = APPDATA_WIDTH / 32;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_INIT = 3'd1;
    localparam logic [2:0] S_WR_DATA   = 3'd2;
    localparam logic [2:0] S_WR_CMD    = 3'd3;
    localparam logic [2:0] S_RD_CMD    = 3'd4;
    localparam logic [2:0] S_RD_DRAIN  = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    localparam logic [ADDR_WIDTH-1:0] STEP   = ADDR_WIDTH'(ADDR_STEP);
    localparam logic [WW-1:0]         W_LAST = WW'(BURST_WORDS - 1);

    // Multiply-by-x Galois step for x^32+x^22+x^2+x+1
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h0040_0007 : 32'h0);
    endfunction

    logic [2:0]            state;
    logic [1:0]            mode_r;
    logic [ADDR_WIDTH-1:0] base_r, addr_r, chk_addr;
    logic [CNT_WIDTH-1:0]  nb_r, cmd_cnt, rcv_bursts;
    logic [31:0]           seed_r, gen_lfsr, chk_lfsr;
    logic [WW-1:0]         wcnt, rwcnt;
    logic [TW-1:0]         tcnt;

    logic wr_go, cmd_go, rd_phase, last_cmd, mismatch, t_expire;
    logic [31:0] seed_fix;

    assign seed_fix = (seed == 32'd0) ? 32'd1 : seed;
    assign wr_go    = (state == S_WR_DATA) && !app_wdf_afull;
    assign cmd_go   = ((state == S_WR_CMD) || (state == S_RD_CMD)) && !app_af_afull;
    assign rd_phase = (state == S_RD_CMD) || (state == S_RD_DRAIN);
    assign last_cmd = (cmd_cnt == nb_r - CNT_WIDTH'(1));
    assign mismatch = (rd_data_fifo_out != {REP{chk_lfsr}});
    assign t_expire = rd_phase && !rd_data_valid && (tcnt == TW'(TIMEOUT - 1));

    assign app_wdf_wren      = wr_go;
    assign app_af_wren       = cmd_go;
    assign app_af_cmd        = (state == S_RD_CMD) ? 3'b001 : 3'b000;
    assign app_af_addr       = addr_r;
    assign app_wdf_data      = {REP{gen_lfsr}};
    assign app_wdf_mask_data = '0;
    assign busy              = (state != S_IDLE);
    assign done              = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            mode_r         <= '0;
            base_r         <= '0;
            addr_r         <= '0;
            chk_addr       <= '0;
            nb_r           <= '0;
            cmd_cnt        <= '0;
            rcv_bursts     <= '0;
            seed_r         <= '0;
            gen_lfsr       <= '0;
            chk_lfsr       <= '0;
            wcnt           <= '0;
            rwcnt          <= '0;
            tcnt           <= '0;
            error          <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    mode_r         <= mode;
                    base_r         <= base_addr;
                    addr_r         <= base_addr;
                    chk_addr       <= base_addr;
                    nb_r           <= num_bursts;
                    seed_r         <= seed_fix;
                    gen_lfsr       <= seed_fix;
                    chk_lfsr       <= seed_fix;
                    cmd_cnt        <= '0;
                    rcv_bursts     <= '0;
                    wcnt           <= '0;
                    rwcnt          <= '0;
                    tcnt           <= '0;
                    error          <= 1'b0;
                    timeout        <= 1'b0;
                    err_count      <= '0;
                    first_err_addr <= '0;
                    state <= (mode == 2'd3 || num_bursts == '0) ? S_DONE : S_WAIT_INIT;
                end
                S_WAIT_INIT: if (phy_init_done)
                    state <= (mode_r == 2'd1) ? S_RD_CMD : S_WR_DATA;
                S_WR_DATA: if (wr_go) begin
                    gen_lfsr <= lfsr_next(gen_lfsr);
                    if (wcnt == W_LAST) begin
                        wcnt  <= '0;
                        state <= S_WR_CMD;
                    end else begin
                        wcnt <= wcnt + WW'(1);
                    end
                end
                S_WR_CMD: if (cmd_go) begin
                    if (!last_cmd) begin
                        cmd_cnt <= cmd_cnt + CNT_WIDTH'(1);
                        addr_r  <= addr_r + STEP;
                        state   <= S_WR_DATA;
                    end else if (mode_r == 2'd2) begin
                        cmd_cnt  <= '0;
                        addr_r   <= base_r;
                        gen_lfsr <= seed_r;
                        state    <= S_RD_CMD;
                    end else begin
                        addr_r <= addr_r + STEP;
                        state  <= S_DONE;
                    end
                end
                S_RD_CMD: if (t_expire) begin
                    state <= S_DONE;
                end else if (cmd_go) begin
                    addr_r <= addr_r + STEP;
                    if (last_cmd) state <= S_RD_DRAIN;
                    else          cmd_cnt <= cmd_cnt + CNT_WIDTH'(1);
                end
                S_RD_DRAIN: if (t_expire || rcv_bursts == nb_r) state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            // Checker and read timeout run only while reads are outstanding
            if (rd_phase) begin
                if (rd_data_valid) begin
                    tcnt     <= '0;
                    chk_lfsr <= lfsr_next(chk_lfsr);
                    if (rwcnt == W_LAST) begin
                        rwcnt      <= '0;
                        chk_addr   <= chk_addr + STEP;
                        rcv_bursts <= rcv_bursts + CNT_WIDTH'(1);
                    end else begin
                        rwcnt <= rwcnt + WW'(1);
                    end
                    if (mismatch) begin
                        error <= 1'b1;
                        if (err_count == '0) first_err_addr <= chk_addr;
                        if (err_count != '1) err_count <= err_count + CNT_WIDTH'(1);
                    end
                end else if (t_expire) begin
                    timeout <= 1'b1;
                    error   <= 1'b1;
                end else begin
                    tcnt <= tcnt + TW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_ddr2_traffic_gen.sv
// Bench for ddr2_traffic_gen: memory model with optional backpressure, corruption
// and silence, plus a polynomial-arithmetic reference for the expected pattern.
module tb_ddr2_traffic_gen;
    localparam int DW = 32, AW = 31, BW = 2, STEP = 4, CW = 16, TO = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, start, phy_init_done, app_af_afull, app_wdf_afull, rd_data_valid;
    logic [1:0] mode;
    logic [AW-1:0] base_addr, app_af_addr, first_err_addr;
    logic [CW-1:0] num_bursts, err_count;
    logic [31:0] seed;
    logic [DW-1:0] rd_data_fifo_out, app_wdf_data;
    logic [DW/8-1:0] app_wdf_mask_data;
    logic [2:0] app_af_cmd;
    logic app_af_wren, app_wdf_wren, busy, done, error, timeout;

    ddr2_traffic_gen dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .base_addr(base_addr),
        .num_bursts(num_bursts), .seed(seed), .phy_init_done(phy_init_done),
        .app_af_afull(app_af_afull), .app_wdf_afull(app_wdf_afull),
        .rd_data_valid(rd_data_valid), .rd_data_fifo_out(rd_data_fifo_out),
        .app_af_wren(app_af_wren), .app_af_addr(app_af_addr), .app_af_cmd(app_af_cmd),
        .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data),
        .app_wdf_mask_data(app_wdf_mask_data), .busy(busy), .done(done), .error(error),
        .timeout(timeout), .err_count(err_count), .first_err_addr(first_err_addr)
    );

    int tests = 0, fails = 0;
    int done_cnt = 0, strobe_cnt = 0, viol = 0, rd_word_idx = 0, flip_idx = -1;
    bit bp_en = 0, no_resp = 0;
    logic [31:0] mem [bit [38:0]];
    logic [31:0] wdf_buf[$], pend[$], wr_data_q[$];
    logic [AW-1:0] waddr_q[$], raddr_q[$];
    logic [31:0] rd_w;
    bit [38:0] key;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // k-th pattern word: seed * x^k in GF(2)[x] / (x^32+x^22+x^2+x+1)
    function automatic logic [31:0] ref_word(input logic [31:0] sd, input int k);
        logic [31:0] s;
        logic [32:0] t;
        s = (sd == 32'd0) ? 32'd1 : sd;
        for (int i = 0; i < k; i++) begin
            t = {s, 1'b0};
            if (t[32]) t = t ^ 33'h1_0040_0007;
            s = t[31:0];
        end
        return s;
    endfunction

    // Memory model: inputs change just after posedge, outputs sampled at negedge
    initial begin
        app_af_afull = 0; app_wdf_afull = 0; rd_data_valid = 0; rd_data_fifo_out = '0;
        forever begin
            @(posedge clk); #1;
            app_af_afull  = bp_en && ($urandom_range(0, 2) == 0);
            app_wdf_afull = bp_en && ($urandom_range(0, 2) == 0);
            if (!reset_n) begin
                pend.delete(); wdf_buf.delete(); rd_data_valid = 0;
            end else if (!no_resp && pend.size() > 0 && (!bp_en || $urandom_range(0, 3) != 0)) begin
                rd_w = pend.pop_front();
                if (rd_word_idx == flip_idx) rd_w[0] = ~rd_w[0];
                rd_word_idx++;
                rd_data_valid = 1; rd_data_fifo_out = rd_w;
            end else begin
                rd_data_valid = 0; rd_data_fifo_out = $urandom;
            end
            @(negedge clk);
            if (done) done_cnt++;
            if (app_wdf_wren) begin
                strobe_cnt++;
                if (app_wdf_afull) viol++;
                wdf_buf.push_back(app_wdf_data);
                wr_data_q.push_back(app_wdf_data);
            end
            if (app_af_wren) begin
                strobe_cnt++;
                if (app_af_afull) viol++;
                if (app_af_cmd == 3'b000) begin
                    waddr_q.push_back(app_af_addr);
                    if (wdf_buf.size() < BW) viol++;
                    for (int i = 0; i < BW; i++) begin
                        key = {app_af_addr, 8'(i)};
                        if (wdf_buf.size() > 0) mem[key] = wdf_buf.pop_front();
                    end
                end else begin
                    raddr_q.push_back(app_af_addr);
                    for (int i = 0; i < BW; i++) begin
                        key = {app_af_addr, 8'(i)};
                        pend.push_back(mem.exists(key) ? mem[key] : 32'h0);
                    end
                end
            end
        end
    end

    task automatic clear_rec();
        wr_data_q.delete(); waddr_q.delete(); raddr_q.delete();
        viol = 0; rd_word_idx = 0;
    endtask

    task automatic kick(input logic [1:0] m, input logic [AW-1:0] b, input int n, input logic [31:0] sd);
        clear_rec();
        @(posedge clk); #1;
        start = 1; mode = m; base_addr = b; num_bursts = CW'(n); seed = sd;
        @(posedge clk); #1;
        start = 0; mode = $urandom; base_addr = $urandom; num_bursts = $urandom; seed = $urandom;
    endtask

    task automatic wait_done(input int d0, input string tag, output int cyc);
        cyc = 0;
        while (done_cnt == d0 && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        check({tag, ":done_seen"}, 64'(done_cnt - d0), 64'd1);
        @(negedge clk);
    endtask

    task automatic verify(input logic [1:0] m, input logic [AW-1:0] b, input int n,
                          input logic [31:0] sd, input string tag);
        int nw, nwc, nrc;
        logic [AW-1:0] ea;
        nw  = (m != 2'd1) ? n * BW : 0;
        nwc = (m != 2'd1) ? n : 0;
        nrc = (m != 2'd0) ? n : 0;
        check({tag, ":wr_words"}, 64'(wr_data_q.size()), 64'(nw));
        for (int k = 0; k < wr_data_q.size() && k < nw; k++)
            check($sformatf("%s:wdata%0d", tag, k), 64'(wr_data_q[k]), 64'(ref_word(sd, k)));
        check({tag, ":wr_cmds"}, 64'(waddr_q.size()), 64'(nwc));
        for (int i = 0; i < waddr_q.size() && i < nwc; i++) begin
            ea = b + AW'(i * STEP);
            check($sformatf("%s:waddr%0d", tag, i), 64'(waddr_q[i]), 64'(ea));
        end
        check({tag, ":rd_cmds"}, 64'(raddr_q.size()), 64'(nrc));
        for (int i = 0; i < raddr_q.size() && i < nrc; i++) begin
            ea = b + AW'(i * STEP);
            check($sformatf("%s:raddr%0d", tag, i), 64'(raddr_q[i]), 64'(ea));
        end
        check({tag, ":afull_violations"}, 64'(viol), 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, d0, s0, n;
        logic [31:0] sd;
        logic [AW-1:0] b;
        reset_n = 0; start = 0; mode = 0; base_addr = 0; num_bursts = 0; seed = 0;
        phy_init_done = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", 64'({busy, done, error, timeout, app_af_wren, app_wdf_wren, app_af_cmd}), 64'd0);
        check("rst_counts", 64'({err_count, first_err_addr}), 64'd0);
        check("rst_bus", 64'({app_af_addr, app_wdf_data, app_wdf_mask_data}), 64'd0);
        @(posedge clk); #1 reset_n = 1;

        // Mode 2, ideal memory; first held in WAIT_INIT
        d0 = done_cnt; s0 = strobe_cnt;
        kick(2'd2, '0, 8, 32'd1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("wait_init_busy", 64'(busy), 64'd1);
        check("wait_init_quiet", 64'(strobe_cnt - s0), 64'd0);
        @(posedge clk); #1 phy_init_done = 1;
        wait_done(d0, "m2_ideal", cyc);
        verify(2'd2, '0, 8, 32'd1, "m2_ideal");
        check("m2_ideal:err", 64'({error, timeout, err_count}), 64'd0);

        // Same job under random backpressure
        bp_en = 1;
        d0 = done_cnt;
        kick(2'd2, '0, 8, 32'd1);
        wait_done(d0, "m2_bp", cyc);
        verify(2'd2, '0, 8, 32'd1, "m2_bp");
        check("m2_bp:err", 64'({error, timeout, err_count}), 64'd0);

        // Randomized jobs
        for (int r = 0; r < 3; r++) begin
            sd = $urandom; b = AW'($urandom) & 31'h7FFF_FFFC; n = $urandom_range(1, 6);
            d0 = done_cnt;
            kick(2'd2, b, n, sd);
            wait_done(d0, $sformatf("rand%0d", r), cyc);
            verify(2'd2, b, n, sd, $sformatf("rand%0d", r));
            check($sformatf("rand%0d:err", r), 64'({error, timeout, err_count}), 64'd0);
        end
        bp_en = 0;

        // Write with seed 5, then read-verify with word 3 corrupted
        d0 = done_cnt;
        kick(2'd0, 31'h100, 4, 32'd5);
        wait_done(d0, "m0_seed5", cyc);
        verify(2'd0, 31'h100, 4, 32'd5, "m0_seed5");
        flip_idx = 3;
        d0 = done_cnt;
        kick(2'd1, 31'h100, 4, 32'd5);
        wait_done(d0, "m1_flip", cyc);
        verify(2'd1, 31'h100, 4, 32'd5, "m1_flip");
        check("m1_flip:err_count", 64'(err_count), 64'd1);
        check("m1_flip:flags", 64'({error, timeout}), 64'b10);
        check("m1_flip:first_err_addr", 64'(first_err_addr), 64'h104);
        flip_idx = -1;

        // Memory never answers
        no_resp = 1;
        d0 = done_cnt;
        kick(2'd1, 31'h100, 2, 32'd5);
        wait_done(d0, "m1_timeout", cyc);
        check("m1_timeout:flags", 64'({error, timeout}), 64'b11);
        check("m1_timeout:waited", 64'(cyc >= TO), 64'd1);
        no_resp = 0;
        pend.delete();

        // Address wrap at the top of the space
        d0 = done_cnt;
        kick(2'd0, 31'h7FFF_FFFC, 2, 32'h1234_5678);
        wait_done(d0, "wrap", cyc);
        verify(2'd0, 31'h7FFF_FFFC, 2, 32'h1234_5678, "wrap");
        check("wrap:second_addr", 64'(waddr_q.size() > 1 ? waddr_q[1] : 31'h7FFF_FFFF), 64'd0);

        // Reset in the middle of a burst
        kick(2'd0, 31'h40, 4, 32'hCAFE_0001);
        cyc = 0;
        while (wr_data_q.size() < 1 && cyc < 100) begin
            @(posedge clk);
            cyc++;
        end
        check("midrst:started", 64'(wr_data_q.size() >= 1), 64'd1);
        #1 reset_n = 0;
        @(posedge clk);
        @(negedge clk);
        check("midrst:strobes", 64'({app_af_wren, app_wdf_wren}), 64'd0);
        check("midrst:outputs", 64'({busy, done, error, app_af_addr, app_wdf_data}), 64'd0);
        s0 = strobe_cnt;
        repeat (3) @(posedge clk);
        #1 reset_n = 1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("midrst:quiet", 64'(strobe_cnt - s0), 64'd0);
        sd = $urandom;
        d0 = done_cnt;
        kick(2'd2, 31'h200, 3, sd);
        wait_done(d0, "postrst", cyc);
        verify(2'd2, 31'h200, 3, sd, "postrst");
        check("postrst:err", 64'({error, timeout, err_count}), 64'd0);

        // Zero bursts and mode 3 are no-ops
        d0 = done_cnt; s0 = strobe_cnt;
        kick(2'd2, 31'h0, 0, 32'd9);
        wait_done(d0, "nb0", cyc);
        check("nb0:latency", 64'(cyc <= 2), 64'd1);
        check("nb0:no_strobes", 64'(strobe_cnt - s0), 64'd0);
        d0 = done_cnt; s0 = strobe_cnt;
        kick(2'd3, 31'h0, 5, 32'd9);
        wait_done(d0, "mode3", cyc);
        check("mode3:latency", 64'(cyc <= 2), 64'd1);
        check("mode3:no_strobes", 64'(strobe_cnt - s0), 64'd0);
        @(negedge clk);
        check("mode3:idle", 64'({busy, done}), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
